// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and the SRAM responder state type.
package ahbl_pkg;

  // HTRANS transfer types
  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransBusy   = 2'b01;
  localparam logic [1:0] HtransNonseq = 2'b10;
  localparam logic [1:0] HtransSeq    = 2'b11;

  // HSIZE transfer sizes supported by 32-bit slaves
  localparam logic [2:0] HsizeByte = 3'd0;
  localparam logic [2:0] HsizeHalf = 3'd1;
  localparam logic [2:0] HsizeWord = 3'd2;

  // HRESP codes
  localparam logic HrespOkay  = 1'b0;
  localparam logic HrespError = 1'b1;

  // SRAM responder data-phase states
  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRd   = 3'd1,
    StWr   = 3'd2,
    StRds  = 3'd3,
    StErr1 = 3'd4,
    StErr2 = 3'd5
  } sram_st_e;

endpackage

// File: rtl/ahbl_sram_slave_if.sv
// AHB-Lite bus signals seen by one subordinate, with master and slave views.
interface ahbl_sram_slave_if;

  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

endinterface

// File: rtl/ahbl_lane_decode.sv
// Byte-lane mask and alignment check for a 32-bit AHB-Lite data bus.
module ahbl_lane_decode
  import ahbl_pkg::*;
(
  input  logic [2:0] hsize_i,
  input  logic [1:0] addr_lo_i,
  output logic [3:0] mask_o,
  output logic       bad_o
);

  // Decode size/offset into lanes; sizes wider than the bus are illegal.
  always_comb begin
    mask_o = 4'b0000;
    bad_o  = 1'b0;
    case (hsize_i)
      HsizeByte: mask_o = 4'b0001 << addr_lo_i;
      HsizeHalf: begin
        mask_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        bad_o  = addr_lo_i[0];
      end
      HsizeWord: begin
        mask_o = 4'b1111;
        bad_o  = |addr_lo_i;
      end
      default: bad_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahbl_sram_slave.sv
// AHB-Lite subordinate fronting a single-port synchronous SRAM (1-cycle read latency).
module ahbl_sram_slave
  import ahbl_pkg::*;
#(
  parameter int unsigned AW          = 10,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  ahbl_sram_slave_if.slave bus,
  output logic             sram_en,
  output logic [3:0]       sram_we,
  output logic [AW-1:0]    sram_addr,
  output logic [31:0]      sram_wdata,
  input  logic [31:0]      sram_rdata
);

  localparam logic [1:0] CntLoad = 2'(WAIT_STATES);

  sram_st_e      state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    mask_q, mask_d;
  logic          rd_first_q, rd_first_d;
  logic [31:0]   hold_q, hold_d;

  logic          acc;
  logic          ready;
  logic          bad;
  logic [3:0]    mask;
  logic [AW-1:0] haddr_word;
  logic          unused_haddr;

  // Upper address bits alias onto the SRAM window.
  assign haddr_word   = bus.HADDR[AW+1:2];
  assign unused_haddr = ^bus.HADDR[31:AW+2];

  // Gating with reset keeps the SRAM strobe quiet while reset is held.
  assign acc = bus.HSEL & bus.HREADY & HRESETn &
               ((bus.HTRANS == HtransNonseq) | (bus.HTRANS == HtransSeq));

  assign sram_wdata = bus.HWDATA;

  ahbl_lane_decode u_lane_decode (
    .hsize_i   (bus.HSIZE),
    .addr_lo_i (bus.HADDR[1:0]),
    .mask_o    (mask),
    .bad_o     (bad)
  );

  // Data-phase behaviour of the current state, then address-phase decode on ready cycles.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    mask_d        = mask_q;
    hold_d        = hold_q;
    rd_first_d    = 1'b0;
    ready         = 1'b0;
    sram_en       = 1'b0;
    sram_we       = 4'b0000;
    sram_addr     = addr_q;
    bus.HREADYOUT = 1'b0;
    bus.HRESP     = HrespOkay;
    bus.HRDATA    = 32'h0;

    unique case (state_q)
      StIdle: ready = 1'b1;
      StRd: begin
        ready      = (cnt_q == 2'd0);
        // SRAM output is only valid the cycle after issue; later cycles replay the copy.
        bus.HRDATA = rd_first_q ? sram_rdata : hold_q;
        if (rd_first_q) begin
          hold_d = sram_rdata;
        end
        if (!ready) begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StWr: begin
        ready = (cnt_q == 2'd0);
        if (ready) begin
          sram_en = 1'b1;
          sram_we = mask_q;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StRds: begin
        // Write has landed at the previous edge; the read issued now sees it.
        sram_en    = 1'b1;
        state_d    = StRd;
        cnt_d      = CntLoad;
        rd_first_d = 1'b1;
      end
      StErr1: begin
        bus.HRESP = HrespError;
        state_d   = StErr2;
      end
      StErr2: begin
        ready     = 1'b1;
        bus.HRESP = HrespError;
      end
      default: state_d = StIdle;
    endcase

    bus.HREADYOUT = ready;

    if (ready) begin
      if (acc) begin
        addr_d = haddr_word;
        mask_d = mask;
        if (bad) begin
          state_d = StErr1;
        end else if (!bus.HWRITE) begin
          if (state_q == StWr) begin
            // SRAM port is busy with the completing write this cycle.
            state_d = StRds;
          end else begin
            state_d    = StRd;
            cnt_d      = CntLoad;
            rd_first_d = 1'b1;
            sram_en    = 1'b1;
            sram_addr  = haddr_word;
          end
        end else begin
          state_d = StWr;
          cnt_d   = CntLoad;
        end
      end else begin
        state_d = StIdle;
      end
    end
  end

  // State and data-phase registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= StIdle;
      cnt_q      <= 2'd0;
      addr_q     <= '0;
      mask_q     <= 4'b0000;
      rd_first_q <= 1'b0;
      hold_q     <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      mask_q     <= mask_d;
      rd_first_q <= rd_first_d;
      hold_q     <= hold_d;
    end
  end

endmodule

// File: tb/tb_ahbl_sram_slave.sv
// Bench for ahbl_sram_slave: three instances (0, 2 and 3 wait states) against a transfer model.
module tb_ahbl_sram_slave;
  import ahbl_pkg::*;

  localparam int unsigned Aw = 10;
  localparam int NDut = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int          sel;
  logic        hsel_c;
  logic [31:0] haddr_c;
  logic [1:0]  htrans_c;
  logic [2:0]  hsize_c;
  logic        hwrite_c;
  logic [31:0] hwdata_c;

  logic [NDut-1:0]         hreadyout_v;
  logic [NDut-1:0]         hresp_v;
  logic [NDut-1:0][31:0]   hrdata_v;
  logic [NDut-1:0]         en_v;
  logic [NDut-1:0][3:0]    we_v;
  logic [NDut-1:0][Aw-1:0] addr_v;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        write;
    logic [31:0] wdata;
  } xfer_t;

  xfer_t       q[$];
  logic [31:0] rd_log[$];
  logic [3:0]  we_log[$];
  logic [31:0] mdl [NDut][2**Aw];

  for (genvar i = 0; i < NDut; i++) begin : g_dut
    localparam int unsigned Ws = (i == 0) ? 0 : ((i == 1) ? 2 : 3);
    ahbl_sram_slave_if bus ();
    logic          sram_en;
    logic [3:0]    sram_we;
    logic [Aw-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata = 32'h0;
    logic [31:0]   mem [2**Aw] = '{default: 32'h0};

    assign bus.HSEL   = hsel_c && (sel == i);
    assign bus.HADDR  = haddr_c;
    assign bus.HTRANS = htrans_c;
    assign bus.HSIZE  = hsize_c;
    assign bus.HWRITE = hwrite_c;
    assign bus.HWDATA = hwdata_c;
    assign bus.HREADY = bus.HREADYOUT;

    ahbl_sram_slave #(.AW(Aw), .WAIT_STATES(Ws)) u_dut (
      .HCLK       (clk),
      .HRESETn    (rst_n),
      .bus        (bus),
      .sram_en    (sram_en),
      .sram_we    (sram_we),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata)
    );

    // Single-port synchronous SRAM
    always @(posedge clk) begin
      if (sram_en) begin
        for (int b = 0; b < 4; b++) begin
          if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
        sram_rdata <= mem[sram_addr];
      end
    end

    assign hreadyout_v[i] = bus.HREADYOUT;
    assign hresp_v[i]     = bus.HRESP;
    assign hrdata_v[i]    = bus.HRDATA;
    assign en_v[i]        = sram_en;
    assign we_v[i]        = sram_we;
    assign addr_v[i]      = sram_addr;
  end

  function automatic int ws_of(input int s);
    return (s == 0) ? 0 : ((s == 1) ? 2 : 3);
  endfunction

  function automatic logic is_bad(input logic [31:0] a, input logic [2:0] s);
    int nb;
    if (s > 3'd2) return 1'b1;
    nb = 1 << s;
    return (a % nb) != 0;
  endfunction

  function automatic logic [3:0] lanes(input logic [31:0] a, input logic [2:0] s);
    int nb;
    logic [7:0] m;
    nb = 1 << s;
    m = 8'((1 << nb) - 1);
    return 4'(m << a[1:0]);
  endfunction

  function automatic logic [Aw-1:0] wordof(input logic [31:0] a);
    return a[Aw+1:2];
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endfunction

  task automatic push(input logic [31:0] a, input logic [2:0] s, input logic w,
                      input logic [31:0] d);
    xfer_t x;
    x.addr = a; x.size = s; x.write = w; x.wdata = d;
    q.push_back(x);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, ".hreadyout"}, 32'(hreadyout_v[sel]), 32'd1);
    chk({tag, ".hresp"}, 32'(hresp_v[sel]), 32'd0);
    chk({tag, ".hrdata"}, hrdata_v[sel], 32'h0);
    chk({tag, ".sram_en"}, 32'(en_v[sel]), 32'd0);
    chk({tag, ".sram_we"}, 32'(we_v[sel]), 32'd0);
  endtask

  // Drives the queued transfers back to back and checks every cycle against the model.
  task automatic run_seq(input string tag);
    int ap, dp, c, len, ws, n, cyc;
    bit dp_valid, stall, last, dbad, dwr, acc_now, wr_ending;
    logic exp_rdy, exp_resp, exp_en;
    logic [31:0] exp_rdata;
    logic [3:0] exp_we, lm;
    logic [Aw-1:0] exp_addr, wd;
    ws = ws_of(sel); n = q.size();
    ap = 0; dp = 0; c = 0; len = 1; cyc = 0; dp_valid = 0; stall = 0;
    while ((ap < n || dp_valid) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ap < n) begin
        hsel_c = 1'b1; htrans_c = HtransNonseq; haddr_c = q[ap].addr;
        hsize_c = q[ap].size; hwrite_c = q[ap].write;
      end else begin
        hsel_c = 1'b0; htrans_c = HtransIdle; hwrite_c = 1'b0;
      end
      hwdata_c = $urandom();
      exp_rdy = 1'b1; exp_resp = 1'b0; exp_en = 1'b0; exp_rdata = 32'h0; exp_we = 4'h0;
      exp_addr = '0; last = 0; dbad = 0; dwr = 0;
      if (dp_valid) begin
        dbad = is_bad(q[dp].addr, q[dp].size);
        dwr  = q[dp].write;
        wd   = wordof(q[dp].addr);
        if (dwr && !dbad) hwdata_c = q[dp].wdata;
        len  = dbad ? 2 : (1 + ws + (stall ? 1 : 0));
        last = (c == len - 1);
        exp_rdy  = last;
        exp_resp = dbad;
        if (!dbad && !dwr && c >= (stall ? 1 : 0)) exp_rdata = mdl[sel][wd];
        if (!dbad && dwr && last) begin
          exp_en = 1'b1; exp_we = lanes(q[dp].addr, q[dp].size); exp_addr = wd;
        end
        if (!dbad && !dwr && stall && c == 0) begin
          exp_en = 1'b1; exp_addr = wd;
        end
      end
      wr_ending = dp_valid && last && dwr && !dbad;
      acc_now = (!dp_valid || last) && (ap < n);
      if (acc_now && !q[ap].write && !is_bad(q[ap].addr, q[ap].size) && !wr_ending) begin
        exp_en = 1'b1; exp_addr = wordof(q[ap].addr);
      end
      #1;
      chk({tag, ".hreadyout"}, 32'(hreadyout_v[sel]), 32'(exp_rdy));
      chk({tag, ".hresp"}, 32'(hresp_v[sel]), 32'(exp_resp));
      chk({tag, ".hrdata"}, hrdata_v[sel], exp_rdata);
      chk({tag, ".sram_en"}, 32'(en_v[sel]), 32'(exp_en));
      chk({tag, ".sram_we"}, 32'(we_v[sel]), 32'(exp_we));
      if (exp_en) chk({tag, ".sram_addr"}, 32'(addr_v[sel]), 32'(exp_addr));
      if (dp_valid && last && !dbad) begin
        if (dwr) begin
          we_log.push_back(we_v[sel]);
          lm = lanes(q[dp].addr, q[dp].size);
          for (int b = 0; b < 4; b++) begin
            if (lm[b]) mdl[sel][wd][8*b +: 8] = q[dp].wdata[8*b +: 8];
          end
        end else begin
          rd_log.push_back(hrdata_v[sel]);
        end
      end
      if (dp_valid && last) dp_valid = 0;
      else if (dp_valid) c++;
      if (acc_now) begin
        stall = wr_ending && !q[ap].write && !is_bad(q[ap].addr, q[ap].size);
        dp = ap; ap++; dp_valid = 1; c = 0;
      end
    end
    if (ap < n || dp_valid) begin
      checks++; failures++;
      $display("FAIL %s.timeout cycles=%0d required below 200", tag, cyc);
    end
    q.delete();
  endtask

  initial begin
    sel = 0; hsel_c = 1'b0; haddr_c = 32'h0; htrans_c = HtransIdle; hsize_c = HsizeWord;
    hwrite_c = 1'b0; hwdata_c = 32'h0;
    for (int d = 0; d < NDut; d++) begin
      for (int k = 0; k < 2**Aw; k++) mdl[d][k] = 32'h0;
    end

    // Reset values on every instance while reset is held
    repeat (3) @(negedge clk);
    for (int d = 0; d < NDut; d++) begin
      sel = d;
      check_quiet("reset");
    end
    sel = 0;
    rst_n = 1'b1;

    // Word write then read of the same address: one RDS stall
    push(32'h10, HsizeWord, 1'b1, 32'hDEADBEEF);
    push(32'h10, HsizeWord, 1'b0, 32'h0);
    run_seq("wr_rd");
    chk("wr_rd.nwe", 32'(we_log.size()), 32'd1);
    if (we_log.size() == 1) chk("wr_rd.we", 32'(we_log[0]), 32'hF);
    chk("wr_rd.nrd", 32'(rd_log.size()), 32'd1);
    if (rd_log.size() == 1) chk("wr_rd.data", rd_log[0], 32'hDEADBEEF);
    we_log.delete(); rd_log.delete();

    // Byte lanes
    push(32'h21, HsizeByte, 1'b1, 32'h11111111);
    push(32'h23, HsizeByte, 1'b1, 32'h22222222);
    push(32'h20, HsizeWord, 1'b0, 32'h0);
    run_seq("bytes");
    chk("bytes.nwe", 32'(we_log.size()), 32'd2);
    if (we_log.size() == 2) begin
      chk("bytes.we0", 32'(we_log[0]), 32'h2);
      chk("bytes.we1", 32'(we_log[1]), 32'h8);
    end
    if (rd_log.size() == 1) chk("bytes.data", rd_log[0], 32'h22001100);
    else chk("bytes.nrd", 32'(rd_log.size()), 32'd1);
    we_log.delete(); rd_log.delete();

    // Misaligned half and oversize transfer give ERROR and leave memory alone
    push(32'h30, HsizeWord, 1'b1, 32'hCAFEF00D);
    push(32'h31, HsizeHalf, 1'b1, 32'h99999999);
    push(32'h30, 3'd3, 1'b0, 32'h0);
    push(32'h30, HsizeWord, 1'b0, 32'h0);
    run_seq("err");
    if (rd_log.size() == 1) chk("err.data", rd_log[0], 32'hCAFEF00D);
    else chk("err.nrd", 32'(rd_log.size()), 32'd1);
    we_log.delete(); rd_log.delete();

    // Zero-wait back-to-back reads
    push(32'h10, HsizeWord, 1'b0, 32'h0);
    push(32'h20, HsizeWord, 1'b0, 32'h0);
    push(32'h30, HsizeWord, 1'b0, 32'h0);
    run_seq("rd3");
    if (rd_log.size() == 3) begin
      chk("rd3.d0", rd_log[0], 32'hDEADBEEF);
      chk("rd3.d1", rd_log[1], 32'h22001100);
      chk("rd3.d2", rd_log[2], 32'hCAFEF00D);
    end else chk("rd3.nrd", 32'(rd_log.size()), 32'd3);
    rd_log.delete();

    // Idle-type transfers and a deselected slave
    @(negedge clk);
    hsel_c = 1'b1; htrans_c = HtransBusy; haddr_c = 32'h10; hsize_c = HsizeWord;
    hwrite_c = 1'b1; hwdata_c = 32'h55555555;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1; check_quiet("busy");
    end
    hsel_c = 1'b0; htrans_c = HtransNonseq;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1; check_quiet("nosel");
    end
    htrans_c = HtransIdle; hwrite_c = 1'b0;
    push(32'h10, HsizeWord, 1'b0, 32'h0);
    run_seq("idle_rd");
    if (rd_log.size() == 1) chk("idle_rd.data", rd_log[0], 32'hDEADBEEF);
    else chk("idle_rd.nrd", 32'(rd_log.size()), 32'd1);
    rd_log.delete();

    // Two wait states: fill four words, then four back-to-back reads
    sel = 1;
    push(32'h0, HsizeWord, 1'b1, 32'h00001000);
    push(32'h4, HsizeWord, 1'b1, 32'h22220004);
    push(32'h8, HsizeWord, 1'b1, 32'h33330008);
    push(32'hC, HsizeWord, 1'b1, 32'h4444000C);
    push(32'h0, HsizeWord, 1'b0, 32'h0);
    push(32'h4, HsizeWord, 1'b0, 32'h0);
    push(32'h8, HsizeWord, 1'b0, 32'h0);
    push(32'hC, HsizeWord, 1'b0, 32'h0);
    run_seq("ws2");
    if (rd_log.size() == 4) begin
      chk("ws2.d0", rd_log[0], 32'h00001000);
      chk("ws2.d3", rd_log[3], 32'h4444000C);
    end else chk("ws2.nrd", 32'(rd_log.size()), 32'd4);
    we_log.delete(); rd_log.delete();

    // Three wait states: reset during a write wait state drops the write
    sel = 2;
    push(32'h40, HsizeWord, 1'b1, 32'hA5A5A5A5);
    run_seq("ws3_wr");
    @(negedge clk);
    hsel_c = 1'b1; htrans_c = HtransNonseq; haddr_c = 32'h40; hsize_c = HsizeWord;
    hwrite_c = 1'b1;
    @(negedge clk);
    hsel_c = 1'b0; htrans_c = HtransIdle; hwrite_c = 1'b0; hwdata_c = 32'h5A5A5A5A;
    #1;
    chk("rstwr.waiting", 32'(hreadyout_v[sel]), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check_quiet("rstwr.now");
    repeat (2) begin
      @(negedge clk); #1; check_quiet("rstwr.held");
    end
    @(negedge clk);
    rst_n = 1'b1;
    chk("rstwr.mem", g_dut[2].mem[16], 32'hA5A5A5A5);
    push(32'h40, HsizeWord, 1'b0, 32'h0);
    run_seq("rstwr_rd");
    if (rd_log.size() == 1) chk("rstwr_rd.data", rd_log[0], 32'hA5A5A5A5);
    else chk("rstwr_rd.nrd", 32'(rd_log.size()), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
